// File: rtl/serial_mag_comp.sv
// serial_mag_comp
//   Multi-cycle magnitude comparator. Captures A/B on an accepted start and
//   compares them MSB-first, DIGIT bits per clock, stopping at the first
//   differing digit. Signed operands are mapped to offset binary at capture
//   (MSB inverted) so the same unsigned digit compare serves both modes.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request a comparison (ignored while busy)
//   A, B         WIDTH-bit operands, sampled on an accepted start
//   signed_mode  1 = two's complement, 0 = unsigned, sampled with operands
//   busy         comparison in progress
//   done         one-cycle pulse when Eq/Lt/Gt update
//   Eq, Lt, Gt   registered result flags, held until the next completion
//
// state | meaning
// IDLE  | waiting for start; result flags hold the last outcome
// RUN   | comparing digit idx_q of the latched operands

module serial_mag_comp #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             Eq,
  output logic             Lt,
  output logic             Gt
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0]    LAST     = IW'(NDIG - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_mag_comp: DIGIT must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  logic [0:0]       state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             done_q;
  logic             eq_q;
  logic             lt_q;
  logic             gt_q;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;

  // Shift the current digit up to the top so the select stays constant.
  always_comb begin
    a_sh  = a_q << (idx_q * DIGIT);
    b_sh  = b_q << (idx_q * DIGIT);
    a_dig = a_sh[WIDTH-1 -: DIGIT];
    b_dig = b_sh[WIDTH-1 -: DIGIT];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A ^ (signed_mode ? MSB_MASK : '0);
            b_q     <= B ^ (signed_mode ? MSB_MASK : '0);
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (a_dig != b_dig) begin
            gt_q    <= (a_dig > b_dig);
            lt_q    <= (a_dig < b_dig);
            eq_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (idx_q == LAST) begin
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b1;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign Eq   = eq_q;
  assign Lt   = lt_q;
  assign Gt   = gt_q;

endmodule
